decode_queue_stage: RTL
=======================

Name: decode_queue_stage

Overview:
- Parametrised successor to the single-entry decode stage: a DEPTH-entry fetch-to-decode instruction queue with valid/ready handshakes on both sides.
- Each head entry is pre-decoded into an instruction class, register fields, extended immediate and a reserved-instruction flag.
- Tracks branch delay slots across pops.
- Sits between fetch and the execute-side control decoder, decoupling fetch stalls from decode stalls.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16
- CNT_W, 3, width of occupancy count; must satisfy 2^CNT_W > DEPTH

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous active-high reset
- flush  in  1  synchronous: discard all entries and the delay-slot state
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept; equals not full
- in_pc  in  32  PC of incoming instruction
- in_inst  in  32  incoming instruction word
- out_valid  out  1  head entry valid (queue not empty)
- out_ready  in  1  downstream accepts head
- out_pc  out  32  head PC
- out_inst  out  32  head instruction word
- out_class  out  4  decoded class of head (see Behaviour)
- out_rs, out_rt, out_rd, out_sa  out  5 each  inst[25:21], [20:16], [15:11], [10:6]
- out_imm  out  32  zero-extended when op[3:2]==2'b11, else sign-extended inst[15:0]
- out_in_slot  out  1  head is in a branch delay slot
- out_ri  out  1  head is a reserved instruction (out_class==4'hF)
- count  out  CNT_W  current occupancy

Behaviour:
- Reset (async): wr_ptr, rd_ptr, count and slot_pending = 0; storage = 0.
  - Outputs: out_valid=0, in_ready=1, count=0; all out_* data fields = 0.
- Push when in_valid && in_ready; pop when out_valid && out_ready. Both may happen in the same cycle; count is then unchanged and the pointers both advance.
- in_ready = (count != DEPTH). There is no full-queue pass-through, so push into a full queue with a simultaneous pop is refused that cycle.
- Latency: an entry pushed in cycle N appears at the head in cycle N+1 at the earliest. There is no bypass from in_* to out_*.
- Pointers wrap modulo DEPTH.
- Pop from empty is ignored; out_ready is a don't-care while out_valid=0.
- While out_valid=0, every out_* data field and out_in_slot/out_ri are driven 0.
- Class decode of head, combinational:
  - 0 ALU_R: R-type arithmetic, logic, shift, MFHI/MFLO
  - 1 ALU_I: ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, and LUI with rs==0
  - 2 LOAD: LB, LBU, LH, LHU, LW
  - 3 STORE: SB, SH, SW
  - 4 BRANCH: BEQ/BNE; BGTZ/BLEZ with rt==0; REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL
  - 5 JUMP: J, JAL
  - 6 JREG: JR, JALR
  - 7 MULDIV: MULT, MULTU, DIV, DIVU, MTHI, MTLO
  - 8 TRAP: SYSCALL, BREAK
  - 9 COP0: MFC0/MTC0, only with DECODE_COP0_EN
  - A ERET: only with DECODE_COP0_EN
  - B NOP: inst==0; takes priority over SLL
  - F RI: everything else
- Delay slot: out_in_slot = slot_pending && out_valid.
  - On each pop, slot_pending <= (popped class is BRANCH, JUMP or JREG).
  - slot_pending persists across empty cycles.
  - A branch in a delay slot sets slot_pending again; no special handling.
- Flush has priority over push and pop in the same cycle.
  - Next cycle: count=0, pointers=0, slot_pending=0, out_valid=0.
  - A push in the flush cycle is dropped; in_ready still reads as not-full that cycle.
- Reset asserted mid-operation clears state immediately regardless of clk.

Optional Feature:
- Macro DECODE_COP0_EN.
- Defined: MFC0 is decoded when inst[31:21]==11'b01000000000 && inst[10:0]==0, and MTC0 when inst[31:21]==11'b01000000100 && inst[10:0]==0; both give class 9. ERET (32'h42000018) gives class A.
- Undefined: all three decode as class F with out_ri=1; no other behaviour changes.

Test Plan:
- Reset, then push 4 entries (pc 0xBFC00000..0xBFC0000C) with out_ready=0 -> count=4, in_ready=0, out_pc=0xBFC00000; a fifth push is refused.
- Queue full, in_valid=1 and out_ready=1 in the same cycle -> pop only; count=3 next cycle, and the pushed word is not stored.
- Push BEQ (0x10220003) then ADDIU (0x24420001), pop both -> BEQ shows out_class=4, out_in_slot=0; ADDIU shows out_class=1, out_in_slot=1, out_imm=0x00000001.
- Push ANDI with imm 0x8000 and ADDI with imm 0x8000 -> out_imm=0x00008000 and 0xFFFF8000 respectively; inst 0 -> class B; LUI with rs=1 -> class F, out_ri=1.
- Three entries queued with slot_pending=1, assert flush together with in_valid -> next cycle count=0, out_valid=0, and the following pop shows out_in_slot=0.
- Push 0x40086000 (MFC0) and 0x42000018 (ERET) -> classes 9 and A with DECODE_COP0_EN defined; class F with out_ri=1 without it.

Source files
------------

// File: rtl/decode_queue_stage.sv
// decode_queue_stage: DEPTH-entry fetch-to-decode instruction queue with
// valid/ready handshakes on both sides. The head entry is pre-decoded into an
// instruction class, register fields and an extended immediate, and the
// stage tracks whether the head sits in a branch delay slot.
// Optional feature: define DECODE_COP0_EN to decode MFC0/MTC0 (class 9) and
// ERET (class A); without it those words decode as reserved (class F).
module decode_queue_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic [3:0]       out_class,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_sa,
    output logic [31:0]      out_imm,
    output logic             out_in_slot,
    output logic             out_ri,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0] CLS_ALU_R  = 4'h0;
    localparam logic [3:0] CLS_ALU_I  = 4'h1;
    localparam logic [3:0] CLS_LOAD   = 4'h2;
    localparam logic [3:0] CLS_STORE  = 4'h3;
    localparam logic [3:0] CLS_BRANCH = 4'h4;
    localparam logic [3:0] CLS_JUMP   = 4'h5;
    localparam logic [3:0] CLS_JREG   = 4'h6;
    localparam logic [3:0] CLS_MULDIV = 4'h7;
    localparam logic [3:0] CLS_TRAP   = 4'h8;
    localparam logic [3:0] CLS_COP0   = 4'h9;
    localparam logic [3:0] CLS_ERET   = 4'hA;
    localparam logic [3:0] CLS_NOP    = 4'hB;
    localparam logic [3:0] CLS_RI     = 4'hF;

    // Instruction class of a raw word; the all-zero word is a NOP, not SLL.
    function automatic logic [3:0] decode_class(input logic [31:0] inst);
        logic [3:0] cls;
        cls = CLS_RI;
        if (inst == 32'h0) begin
            cls = CLS_NOP;
        end else begin
            case (inst[31:26])
                6'h00: begin
                    case (inst[5:0])
                        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                        6'h10, 6'h12,
                        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                        6'h26, 6'h27, 6'h2A, 6'h2B:           cls = CLS_ALU_R;
                        6'h08, 6'h09:                         cls = CLS_JREG;
                        6'h0C, 6'h0D:                         cls = CLS_TRAP;
                        6'h11, 6'h13,
                        6'h18, 6'h19, 6'h1A, 6'h1B:           cls = CLS_MULDIV;
                        default:                              cls = CLS_RI;
                    endcase
                end
                6'h01: begin
                    case (inst[20:16])
                        5'h00, 5'h01, 5'h10, 5'h11: cls = CLS_BRANCH;
                        default:                    cls = CLS_RI;
                    endcase
                end
                6'h02, 6'h03: cls = CLS_JUMP;
                6'h04, 6'h05: cls = CLS_BRANCH;
                6'h06, 6'h07: cls = (inst[20:16] == 5'h0) ? CLS_BRANCH : CLS_RI;
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: cls = CLS_ALU_I;
                6'h0F: cls = (inst[25:21] == 5'h0) ? CLS_ALU_I : CLS_RI;
                6'h10: begin
`ifdef DECODE_COP0_EN
                    if (inst == 32'h4200_0018) begin
                        cls = CLS_ERET;
                    end else if (inst[10:0] == 11'h0 &&
                                 (inst[31:21] == 11'b01000000000 ||
                                  inst[31:21] == 11'b01000000100)) begin
                        cls = CLS_COP0;
                    end
`endif
                end
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: cls = CLS_LOAD;
                6'h28, 6'h29, 6'h2B:               cls = CLS_STORE;
                default:                           cls = CLS_RI;
            endcase
        end
        return cls;
    endfunction

    // Control transfers whose successor executes in a delay slot.
    function automatic logic opens_slot(input logic [3:0] cls);
        return (cls == CLS_BRANCH) || (cls == CLS_JUMP) || (cls == CLS_JREG);
    endfunction

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             slot_pending_q;

    logic             push, pop, not_empty;
    logic [31:0]      head_pc, head_inst;
    logic [3:0]       head_cls;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready && !flush;
    assign pop       = not_empty && out_ready && !flush;
    assign head_pc   = pc_q[rd_ptr_q];
    assign head_inst = inst_q[rd_ptr_q];
    assign head_cls  = decode_class(head_inst);

    // Occupancy next state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers, occupancy and delay-slot tracking; flush wins over push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            slot_pending_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            slot_pending_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q       <= rd_ptr_q + PTR_W'(1);
                slot_pending_q <= opens_slot(head_cls);
            end
            count_q <= count_d;
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (push) begin
            pc_q[wr_ptr_q]   <= in_pc;
            inst_q[wr_ptr_q] <= in_inst;
        end
    end

    // Head outputs, forced to zero while the queue is empty.
    always_comb begin
        out_valid   = not_empty;
        out_pc      = '0;
        out_inst    = '0;
        out_class   = '0;
        out_rs      = '0;
        out_rt      = '0;
        out_rd      = '0;
        out_sa      = '0;
        out_imm     = '0;
        out_in_slot = 1'b0;
        out_ri      = 1'b0;
        if (not_empty) begin
            out_pc      = head_pc;
            out_inst    = head_inst;
            out_class   = head_cls;
            out_rs      = head_inst[25:21];
            out_rt      = head_inst[20:16];
            out_rd      = head_inst[15:11];
            out_sa      = head_inst[10:6];
            out_imm     = (head_inst[29:28] == 2'b11) ? {16'h0, head_inst[15:0]}
                                                      : {{16{head_inst[15]}}, head_inst[15:0]};
            out_in_slot = slot_pending_q;
            out_ri      = (head_cls == CLS_RI);
        end
    end

    assign count = count_q;

endmodule
